// File: rtl/stream_mux_nx1_pkg.sv
// Shared constants for the N:1 stream multiplexer.
// Mode encoding is common to the mux and anything that drives it.
package stream_mux_nx1_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

endpackage

// File: rtl/stream_mux_nx1_if.sv
// Handshake bundle between N input channels, the mux and one consumer.
// slave is the mux side, master is the producer/consumer side.
interface stream_mux_nx1_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_ready;

    modport slave (
        input  mode,
        input  sel,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_chan
    );

    modport master (
        output mode,
        output sel,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_chan
    );

endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational wrap-around priority search starting just after ptr.
// ptr itself is examined last, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    localparam logic [SELW:0] NW = (SELW+1)'(N);

    logic [SELW:0] idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, ptr} + (SELW+1)'(k);
            if (idx >= NW) begin
                idx = idx - NW;
            end
            if (req[idx[SELW-1:0]]) begin
                grant       = idx[SELW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream mux with static or round-robin selection.
// One registered output beat; accepts a new beat whenever the slot frees.
module stream_mux_nx1
    import stream_mux_nx1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_mux_nx1_if.slave   bus
);

    localparam int SELW = $clog2(N);

    logic [SELW-1:0]  ptr_q;
    logic             ov_q;
    logic [WIDTH-1:0] od_q;
    logic [SELW-1:0]  oc_q;

    logic [SELW-1:0]  rr_gnt;
    logic             rr_gv;
    logic             st_gv;
    logic [SELW-1:0]  grant;
    logic             gv;
    logic             slot_free;
    logic             xfer;
    logic [N-1:0]     rdy;
    logic [WIDTH-1:0] data_sel;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req         (bus.in_valid),
        .ptr         (ptr_q),
        .grant       (rr_gnt),
        .grant_valid (rr_gv)
    );

    // Out-of-range sel never matches any channel, so it grants nothing.
    always_comb begin
        st_gv = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i)) begin
                st_gv = bus.in_valid[i];
            end
        end
    end

    always_comb begin
        unique case (1'b1)
            (bus.mode == MODE_RR): begin
                grant = rr_gnt;
                gv    = rr_gv;
            end
            default: begin
                grant = bus.sel;
                gv    = st_gv;
            end
        endcase
    end

    assign slot_free = !ov_q || bus.out_ready;
    assign xfer      = gv && slot_free && rst_n;

    always_comb begin
        rdy      = '0;
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                rdy[i]   = xfer;
                data_sel = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q  <= 1'b0;
            od_q  <= '0;
            oc_q  <= '0;
            ptr_q <= SELW'(N-1);
        end else if (xfer) begin
            ov_q  <= 1'b1;
            od_q  <= data_sel;
            oc_q  <= grant;
            ptr_q <= grant;
        end else if (bus.out_ready) begin
            ov_q  <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_chan  = oc_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed bench for stream_mux_nx1 with a per-cycle reference model.
// A second N=3 instance exercises the out-of-range static select.
module tb_stream_mux_nx1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stream_mux_nx1_if #(.WIDTH(8), .N(4)) bus_a ();
    stream_mux_nx1_if #(.WIDTH(8), .N(3)) bus_b ();

    stream_mux_nx1 #(.WIDTH(8), .N(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    stream_mux_nx1 #(.WIDTH(8), .N(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic [7:0] dat [4];
    assign bus_a.in_data = {dat[3], dat[2], dat[1], dat[0]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the beat the output register must hold.
    int         m_ptr;
    bit         m_v;
    logic [7:0] m_d;
    int         m_c;

    always @(negedge clk) begin
        int   g;
        bit   gv;
        bit   slot;
        logic [3:0] er;
        if (!rst_n) begin
            m_v   = 1'b0;
            m_d   = 8'h00;
            m_c   = 0;
            m_ptr = 3;
            chk("rst_out_valid", bus_a.out_valid, 0);
            chk("rst_in_ready", bus_a.in_ready, 0);
            chk("rst_out_data", bus_a.out_data, 0);
            chk("rst_out_chan", bus_a.out_chan, 0);
        end else begin
            gv = 1'b0;
            g  = 0;
            if (bus_a.mode == 1'b0) begin
                if (bus_a.in_valid[bus_a.sel]) begin
                    gv = 1'b1;
                    g  = int'(bus_a.sel);
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_ptr + k) % 4;
                    if (!gv && bus_a.in_valid[c]) begin
                        gv = 1'b1;
                        g  = c;
                    end
                end
            end
            slot = !m_v || bus_a.out_ready;
            er   = (gv && slot) ? 4'(1 << g) : 4'b0000;
            chk("model_in_ready", bus_a.in_ready, er);
            chk("model_out_valid", bus_a.out_valid, m_v);
            if (m_v) begin
                chk("model_out_data", bus_a.out_data, m_d);
                chk("model_out_chan", bus_a.out_chan, m_c);
            end
            if (gv && slot) begin
                m_v   = 1'b1;
                m_d   = dat[g];
                m_c   = g;
                m_ptr = g;
            end else if (bus_a.out_ready) begin
                m_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic md, input logic [1:0] s,
                         input logic [3:0] v, input logic r);
        bus_a.mode      = md;
        bus_a.sel       = s;
        bus_a.in_valid  = v;
        bus_a.out_ready = r;
    endtask

    // {mode, sel[1:0], out_ready, in_valid[3:0]}
    logic [7:0] vec [16];

    initial begin
        int exp_seq [5];
        vec = '{8'h9F, 8'h85, 8'h8A, 8'h06, 8'h5F, 8'h40,
                8'h1C, 8'h93, 8'h8F, 8'hF1, 8'h98, 8'h33,
                8'h80, 8'h9E, 8'h27, 8'h8C};
        exp_seq = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
        bus_b.mode      = 1'b0;
        bus_b.sel       = 2'd3;
        bus_b.in_valid  = 3'b111;
        bus_b.in_data   = 24'h332211;
        bus_b.out_ready = 1'b1;

        tick();
        tick();
        rst_n = 1'b1;

        // Round-robin over all four channels, one beat per cycle.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_seq_chan", bus_a.out_chan, exp_seq[k]);
            chk("rr_seq_valid", bus_a.out_valid, 1);
        end

        // Static select of channel 2.
        dat[2] = 8'hA5;
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        #1;
        chk("static_in_ready", bus_a.in_ready, 4'b0100);
        tick();
        chk("static_out_data", bus_a.out_data, 8'hA5);
        chk("static_out_chan", bus_a.out_chan, 2);

        // Backpressure: held beat frozen, no new beat accepted.
        bus_a.out_ready = 1'b0;
        dat[2] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", bus_a.in_ready, 0);
            tick();
            chk("stall_out_data", bus_a.out_data, 8'hA5);
            chk("stall_out_chan", bus_a.out_chan, 2);
        end
        bus_a.out_ready = 1'b1;
        tick();
        chk("resume_out_data", bus_a.out_data, 8'h5A);
        chk("resume_out_valid", bus_a.out_valid, 1);

        // Wrap-around between channels 3 and 0.
        drive(1'b1, 2'd0, 4'b0001, 1'b1);
        tick();
        chk("wrap_seed_chan", bus_a.out_chan, 0);
        bus_a.in_valid = 4'b1001;
        tick();
        chk("wrap_chan_a", bus_a.out_chan, 3);
        tick();
        chk("wrap_chan_b", bus_a.out_chan, 0);
        tick();
        chk("wrap_chan_c", bus_a.out_chan, 3);

        // Static select of an idle channel, and sel >= N on the N=3 build.
        drive(1'b0, 2'd2, 4'b1011, 1'b1);
        #1;
        chk("idle_sel_in_ready", bus_a.in_ready, 0);
        chk("n3_in_ready", bus_b.in_ready, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("idle_sel_out_valid", bus_a.out_valid, 0);
            chk("n3_out_valid", bus_b.out_valid, 0);
            chk("n3_in_ready_hold", bus_b.in_ready, 0);
        end

        // Reset mid-stream with a held beat.
        dat[2] = 8'hC3;
        drive(1'b1, 2'd0, 4'b0100, 1'b0);
        tick();
        chk("pre_rst_out_valid", bus_a.out_valid, 1);
        chk("pre_rst_out_chan", bus_a.out_chan, 2);
        bus_a.in_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus_a.out_valid, 0);
        chk("async_rst_in_ready", bus_a.in_ready, 0);
        chk("async_rst_out_data", bus_a.out_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        chk("post_rst_chan", bus_a.out_chan, 0);
        chk("post_rst_valid", bus_a.out_valid, 1);

        // Mixed vectors checked against the model only.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            drive(vec[k][7], vec[k][6:5], vec[k][3:0], vec[k][4]);
            tick();
        end
        drive(1'b1, 2'd0, 4'h0, 1'b1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_nx1.md
STREAM_MUX_NX1 -- requirements
Module: stream_mux_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter N, default 4, number of input channels (N >= 2).
REQ-003 SHALL derive local parameter SELW = clog2(N), channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode  input  1  0 = static select, 1 = round-robin.
REQ-007 SHALL have port sel  input  SELW  channel index used in static mode.
REQ-008 SHALL have port in_valid  input  N  per-channel valid, bit i = channel i.
REQ-009 SHALL have port in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_ready  output  N  per-channel ready, at most one bit high.
REQ-011 SHALL have port out_valid  output  1  output register holds a beat.
REQ-012 SHALL have port out_data  output  WIDTH  registered data of the held beat.
REQ-013 SHALL have port out_chan  output  SELW  source channel of the held beat.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the held beat.

Function
REQ-015 SHALL define a transfer on channel i as in_valid[i] && in_ready[i] at a rising clk edge, and an output transfer as out_valid && out_ready.
REQ-016 SHALL define slot_free = !out_valid || out_ready.
REQ-017 SHALL, in static mode, set grant = sel when sel < N and in_valid[sel] = 1, otherwise no grant.
REQ-018 SHALL, in static mode with sel >= N, assert no in_ready and load no beat.
REQ-019 SHALL, in round-robin mode, grant the first valid channel searching from ptr+1 upward, wrapping N-1 -> 0, with ptr itself searched last.
REQ-020 SHALL drive in_ready[grant] = slot_free and all other in_ready bits 0; with no grant, all in_ready bits are 0.
REQ-021 SHALL, on a channel transfer, load out_data <= that channel's data, out_chan <= grant and out_valid <= 1, one-cycle input-to-output latency.
REQ-022 SHALL, on an output transfer with no channel transfer in the same cycle, clear out_valid.
REQ-023 SHALL, on a simultaneous output transfer and channel transfer, replace the beat with the new beat; out_valid stays 1 and throughput is one beat per cycle.
REQ-024 SHALL hold out_data and out_chan stable while out_valid && !out_ready.
REQ-025 SHALL update ptr <= grant on every channel transfer in either mode, and leave ptr unchanged otherwise.
REQ-026 SHALL apply mode or sel changes at the next arbitration only; a held beat is never altered.

Reset
REQ-027 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_chan = 0, ptr = N-1 and all in_ready = 0, independent of clk.
REQ-028 SHALL discard a beat held in the output register when reset is asserted mid-operation.
REQ-029 SHALL, after reset release, give channel 0 highest round-robin priority on the first arbitration.

Structure
REQ-030 SHALL place the MODE_STATIC = 0 and MODE_RR = 1 constants in the shared project package/header.
REQ-031 SHALL implement the wrap-around priority search as sub-module rr_arbiter (inputs req[N] and ptr, output grant index and grant-valid), purely combinational.
REQ-032 SHALL keep all registers (output beat, out_chan, ptr) in stream_mux_nx1.

Verification
REQ-033 SHALL cover: after reset, mode=1, all four in_valid=1 with out_ready=1 -> out_chan sequence 0,1,2,3,0, one beat per cycle.
REQ-034 SHALL cover: mode=0, sel=2, in_valid=4'b1111, in_data[2]=8'hA5 -> only in_ready[2] high; out_data=8'hA5, out_chan=2 one cycle later.
REQ-035 SHALL cover: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_chan unchanged and in_ready=0 throughout; no beat lost when out_ready returns.
REQ-036 SHALL cover: mode=1, in_valid=4'b1001 with ptr=0 -> grant 3, then 0, then 3 (wrap-around).
REQ-037 SHALL cover: mode=0, sel=2 with in_valid[2]=0, and the N=3 build with sel=3 -> no in_ready asserted and out_valid stays 0.
REQ-038 SHALL cover: rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately without a clock edge; the first grant after release is channel 0.
